// File: rtl/sample_tx_pkg.sv
// Shared FSM state type and framing constants for the sample UART transmitter.
// Define SAMPLE_TX_MARKER_EN to send a marker byte ahead of every sample.
package sample_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [7:0] MARKER_BYTE = 8'hA5;

`ifdef SAMPLE_TX_MARKER_EN
    localparam int BYTES_PER_SAMPLE = 3;
`else
    localparam int BYTES_PER_SAMPLE = 2;
`endif

endpackage

// File: rtl/tx_sample_fifo.sv
// Sample buffer for the UART transmitter: first-word-fall-through FIFO.
// The read data always shows the oldest entry; writes while full are ignored.
module tx_sample_fifo
    import sample_tx_pkg::*;
#(
    parameter int BITS = 16,
    parameter int SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [BITS-1:0]       wr_data,
    input  logic                  rd_en,
    output logic [BITS-1:0]       rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(SIZE):0] fill
);

    localparam int AW = $clog2(SIZE);

    logic [BITS-1:0] mem [SIZE];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_wr;
    logic            do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(SIZE));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign fill    = count;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because SIZE is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_uart_tx.sv
// Buffers 16-bit audio samples and sends each as two 8N1 bytes (low, high) with cts gating.
// Define SAMPLE_TX_MARKER_EN to prefix every sample with the marker byte.
module sample_uart_tx
    import sample_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 52,
    parameter int BITS           = 16,
    parameter int FIFO_SIZE      = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_valid,
    input  logic [BITS-1:0]            sample_data,
    output logic                       sample_ready,
    input  logic                       cts,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(FIFO_SIZE):0] fill,
    output logic                       overflow
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

    tx_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]      bit_idx, idx_next;
    logic            hi_byte, hi_next;
    logic [BITS-1:0] shift_reg, shift_next;
    logic            tx_q, tx_next;
    logic            busy_q;
    logic            overflow_q;
    logic            launch;
    logic            start_ok;
    logic [7:0]      cur_byte;

    logic            fifo_empty;
    logic            fifo_full;
    logic [BITS-1:0] fifo_rd_data;

`ifdef SAMPLE_TX_MARKER_EN
    logic            marker_phase, mark_next;
`endif

    tx_sample_fifo #(
        .BITS (BITS),
        .SIZE (FIFO_SIZE)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (sample_valid),
        .wr_data (sample_data),
        .rd_en   (launch),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .fill    (fill)
    );

    assign sample_ready = !fifo_full;
    assign start_ok     = !fifo_empty && cts;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;

`ifdef SAMPLE_TX_MARKER_EN
    assign cur_byte = marker_phase ? MARKER_BYTE : shift_reg[7:0];
`else
    assign cur_byte = shift_reg[7:0];
`endif

    // cts is only consulted when a new sample would begin; once begun, all its bytes run back to back.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        hi_next    = hi_byte;
        shift_next = shift_reg;
`ifdef SAMPLE_TX_MARKER_EN
        mark_next  = marker_phase;
`endif
        launch     = 1'b0;
        tx_next    = STOP_BIT;
        case (state)
            IDLE: begin
                launch = start_ok;
            end
            START: begin
                tx_next = START_BIT;
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = CNT_MAX;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                tx_next = cur_byte[bit_idx];
                if (cnt == '0) begin
                    cnt_next = CNT_MAX;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (hi_byte) begin
                    launch     = start_ok;
                    state_next = IDLE;
                    cnt_next   = '0;
                    hi_next    = 1'b0;
                end else begin
                    state_next = START;
                    cnt_next   = CNT_MAX;
`ifdef SAMPLE_TX_MARKER_EN
                    if (marker_phase) begin
                        mark_next = 1'b0;
                    end else begin
                        hi_next    = 1'b1;
                        shift_next = {8'h00, shift_reg[BITS-1:8]};
                    end
`else
                    hi_next    = 1'b1;
                    shift_next = {8'h00, shift_reg[BITS-1:8]};
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (launch) begin
            state_next = START;
            cnt_next   = CNT_MAX;
            hi_next    = 1'b0;
            shift_next = fifo_rd_data;
`ifdef SAMPLE_TX_MARKER_EN
            mark_next  = 1'b1;
`endif
        end
    end

    // tx and busy are registered, so the line lags the FSM state by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            hi_byte   <= 1'b0;
            shift_reg <= '0;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
`ifdef SAMPLE_TX_MARKER_EN
            marker_phase <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= idx_next;
            hi_byte   <= hi_next;
            shift_reg <= shift_next;
            tx_q      <= tx_next;
            busy_q    <= (state != IDLE);
`ifdef SAMPLE_TX_MARKER_EN
            marker_phase <= mark_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (sample_valid && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed self-checking bench for sample_uart_tx: framing, flow control, overflow, reset abort.
// Honours SAMPLE_TX_MARKER_EN by expecting an A5 frame ahead of each sample.
module tb_sample_uart_tx;

    localparam int CPB   = 52;
    localparam int DEPTH = 16;
    localparam int HALF  = CPB / 2;
    localparam int BOUND = 3 * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        cts = 1'b0;
    logic        sample_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fill;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    sample_uart_tx #(
        .CLOCKS_PER_BIT (CPB),
        .BITS           (16),
        .FIFO_SIZE      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .cts          (cts),
        .tx           (tx),
        .busy         (busy),
        .fill         (fill),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one sample for a single clock; returns at the following falling edge.
    task automatic apply_stimulus(input logic [15:0] data);
        sample_data  = data;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle_window(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check_output(tag, bad, 0);
    endtask

    // Waits for a start bit, then samples every bit at its centre; ends at the middle of the stop bit.
    task automatic expect_frame(input string tag, input logic [7:0] exp, input bit drop_cts, output int gap);
        int waited = 0;
        logic [7:0] got = '0;
        while (tx !== 1'b0 && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        gap = waited;
        check_output({tag, " start found"}, waited < BOUND, 1'b1);
        if (waited >= BOUND) return;
        repeat (HALF) @(negedge clk);
        check_output({tag, " start bit"}, tx, 1'b0);
        check_output({tag, " busy"}, busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            got[i] = tx;
            if (drop_cts && i == 3) cts = 1'b0;
        end
        check_output({tag, " data"}, got, exp);
        repeat (CPB) @(negedge clk);
        check_output({tag, " stop bit"}, tx, 1'b1);
    endtask

    task automatic expect_sample(input string tag, input logic [15:0] data, input bit drop_cts, output int first_gap);
        int g;
`ifdef SAMPLE_TX_MARKER_EN
        expect_frame({tag, " marker"}, 8'hA5, drop_cts, first_gap);
        expect_frame({tag, " low"}, data[7:0], 1'b0, g);
        check_output({tag, " low gap"}, g, CPB - HALF);
`else
        expect_frame({tag, " low"}, data[7:0], drop_cts, first_gap);
`endif
        expect_frame({tag, " high"}, data[15:8], 1'b0, g);
        check_output({tag, " high gap"}, g, CPB - HALF);
    endtask

    initial begin
        int gap;
        logic [15:0] ovf_vals [DEPTH];

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst tx", tx, 1'b1);
        check_output("rst busy", busy, 1'b0);
        check_output("rst fill", fill, 5'd0);
        check_output("rst overflow", overflow, 1'b0);
        check_output("rst ready", sample_ready, 1'b1);
        reset_n = 1'b1;
        cts = 1'b1;
        idle_window("post-reset idle", 20);

        // Single sample: latency, bit order, total frame length
        $display("[TB] single sample BEEF");
        apply_stimulus(16'hBEEF);
        check_output("beef fill after accept", fill, 5'd1);
        check_output("beef tx edge1", tx, 1'b1);
        @(negedge clk);
        check_output("beef tx edge2 still high", tx, 1'b1);
        check_output("beef popped", fill, 5'd0);
        @(negedge clk);
        check_output("beef tx falls edge3", tx, 1'b0);
        expect_sample("beef", 16'hBEEF, 1'b0, gap);
        check_output("beef immediate start", gap, 0);
        repeat (HALF - 1) @(negedge clk);
        check_output("beef busy last cycle", busy, 1'b1);
        @(negedge clk);
        check_output("beef busy done", busy, 1'b0);
        check_output("beef tx idle", tx, 1'b1);
        check_output("beef fill end", fill, 5'd0);

        // Flow control, then simultaneous write and pop
        $display("[TB] flow control");
        cts = 1'b0;
        apply_stimulus(16'h1234);
        apply_stimulus(16'h00FF);
        apply_stimulus(16'h8001);
        idle_window("cts low idle", 100);
        check_output("cts low fill", fill, 5'd3);
        cts = 1'b1;
        apply_stimulus(16'h7E81);
        check_output("write+pop fill", fill, 5'd3);
        expect_sample("fc0", 16'h1234, 1'b0, gap);
        expect_sample("fc1", 16'h00FF, 1'b0, gap);
        check_output("fc1 no gap", gap, CPB - HALF);
        expect_sample("fc2", 16'h8001, 1'b0, gap);
        check_output("fc2 no gap", gap, CPB - HALF);
        expect_sample("fc3", 16'h7E81, 1'b0, gap);
        check_output("fc3 no gap", gap, CPB - HALF);
        repeat (HALF + 2) @(negedge clk);
        check_output("fc busy done", busy, 1'b0);
        check_output("fc fill end", fill, 5'd0);

        // cts falls mid-sample: sample completes, next one waits
        $display("[TB] cts drop mid-sample");
        apply_stimulus(16'hC3A6);
        expect_sample("ctsdrop", 16'hC3A6, 1'b1, gap);
        apply_stimulus(16'h5AC3);
        idle_window("ctsdrop hold", 300);
        check_output("ctsdrop fill", fill, 5'd1);
        check_output("ctsdrop busy", busy, 1'b0);
        cts = 1'b1;
        expect_sample("ctsresume", 16'h5AC3, 1'b0, gap);
        repeat (CPB) @(negedge clk);

        // Overflow
        $display("[TB] overflow");
        cts = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ovf_vals[i] = 16'h3C00 + 16'(i) * 16'h0101;
            apply_stimulus(ovf_vals[i]);
        end
        check_output("full ready", sample_ready, 1'b0);
        check_output("full fill", fill, 5'd16);
        check_output("full no overflow yet", overflow, 1'b0);
        apply_stimulus(16'hDEAD);
        check_output("ovf fill", fill, 5'd16);
        check_output("ovf flag", overflow, 1'b1);
        cts = 1'b1;
        apply_stimulus(16'hDEAE);
        check_output("ovf write+pop fill", fill, 5'd15);
        check_output("ovf sticky", overflow, 1'b1);
        check_output("ovf ready again", sample_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            expect_sample($sformatf("ovf%0d", i), ovf_vals[i], 1'b0, gap);
            if (i > 0) check_output($sformatf("ovf%0d gap", i), gap, CPB - HALF);
        end
        repeat (CPB) @(negedge clk);
        idle_window("ovf dropped never sent", BOUND);
        check_output("ovf fill end", fill, 5'd0);
        check_output("ovf still sticky", overflow, 1'b1);

        // Reset in the middle of a data bit
        $display("[TB] reset mid-frame");
        apply_stimulus(16'hF00F);
        apply_stimulus(16'h0FF0);
        gap = 0;
        while (tx !== 1'b0 && gap < BOUND) begin
            @(negedge clk);
            gap++;
        end
        check_output("rstmid frame started", gap < BOUND, 1'b1);
        repeat (HALF + 5 * CPB) @(negedge clk);
        check_output("rstmid data bit low", tx, 1'b0);
        check_output("rstmid fill before", fill, 5'd1);
        reset_n = 1'b0;
        #1;
        check_output("rstmid tx", tx, 1'b1);
        check_output("rstmid busy", busy, 1'b0);
        check_output("rstmid fill", fill, 5'd0);
        check_output("rstmid overflow", overflow, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_window("rstmid silent", BOUND);
        check_output("rstmid fill after", fill, 5'd0);
        apply_stimulus(16'h6996);
        expect_sample("post-reset", 16'h6996, 1'b0, gap);
        repeat (CPB) @(negedge clk);
        check_output("post-reset idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
